// File: rtl/scrypt_header_loader.sv
// Assembles an 80-byte block header from a 32-bit word stream, then sweeps the nonce
// field, issuing one start pulse per hash to the HMAC-SHA256 key-hash stage.
//
// state | meaning
// LOAD  | accepting header words into slot word_cnt
// FIRE  | enable high for one cycle, header stable
// WAIT  | waiting for hash_done from the key-hash stage
// DONE  | sweep_done pulse, header kept on data
module scrypt_header_loader #(
  parameter int HDR_WORDS  = 20,
  parameter int NONCE_WORD = 19
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [31:0]              word_in,
  input  logic                     word_valid,
  output logic                     word_ready,
  input  logic [31:0]              nonce_limit,
  input  logic                     abort,
  input  logic                     hash_done,
  output logic [32*HDR_WORDS-1:0]  data,
  output logic                     enable,
  output logic [31:0]              cur_nonce,
  output logic                     busy,
  output logic                     sweep_done
);

  localparam int CNT_W = $clog2(HDR_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(HDR_WORDS - 1);

  typedef enum logic [1:0] {LOAD, FIRE, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [31:0]      limit;

  assign cur_nonce = data[32*NONCE_WORD +: 32];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= LOAD;
      word_cnt   <= '0;
      limit      <= '0;
      data       <= '0;
      enable     <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      word_ready <= 1'b1;
    end else begin
      enable     <= 1'b0;
      sweep_done <= 1'b0;
      // abort wins over word acceptance and hash_done in the same cycle
      if (abort) begin
        state      <= LOAD;
        word_cnt   <= '0;
        busy       <= 1'b0;
        word_ready <= 1'b1;
      end else begin
        case (state)
          LOAD: begin
            if (word_valid && word_ready) begin
              for (int k = 0; k < HDR_WORDS; k++) begin
                if (word_cnt == CNT_W'(k)) data[32*k +: 32] <= word_in;
              end
              if (word_cnt == LAST_WORD) begin
                limit      <= nonce_limit;
                word_cnt   <= '0;
                state      <= FIRE;
                enable     <= 1'b1;
                busy       <= 1'b1;
                word_ready <= 1'b0;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end
          end
          FIRE: state <= WAIT;
          WAIT: begin
            if (hash_done) begin
              if (cur_nonce == limit) begin
                state      <= DONE;
                sweep_done <= 1'b1;
                busy       <= 1'b0;
              end else begin
                data[32*NONCE_WORD +: 32] <= cur_nonce + 32'd1;
                state  <= FIRE;
                enable <= 1'b1;
              end
            end
          end
          DONE: begin
            state      <= LOAD;
            word_ready <= 1'b1;
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule
